test_pattern_gen: RTL
=====================

Name: test_pattern_gen

Overview:
- Parametrised overlay test-pattern generator for the danmaku video path, driven by the timing generator's hcnt/vcnt/hsize/vsize.
- Produces one registered RGBA pixel per pxlClk from six selectable patterns.
- Pattern changes come from either a host pattern load or an automatic dwell-based cycle.
- Pattern changes and frame geometry take effect only at frame start, so no frame ever shows a torn pattern.

Parameters:
- CNT_W, 12, width of hcnt/vcnt/hsize/vsize and of all internal position registers.
- CHECK_LOG2, 4, checkerboard cell edge is 2^CHECK_LOG2 pixels.
- DWELL_FRAMES, 60, frames each pattern is shown in auto mode (>=1).
- NUM_PAT, 6, number of implemented patterns (fixed at 6; the parameter is exposed for range checks).

Ports:
- pxlClk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-low.
- hcnt  in  CNT_W  current pixel column.
- vcnt  in  CNT_W  current pixel row.
- hsize  in  CNT_W  active width.
- vsize  in  CNT_W  active height.
- pause  in  1  high: freeze dwell counter and scroll position.
- auto_en  in  1  high: automatic pattern cycling.
- pat_sel  in  3  requested pattern.
- pat_load  in  1  one-cycle strobe; captures pat_sel.
- pixel_r_out  out  8  red.
- pixel_g_out  out  8  green.
- pixel_b_out  out  8  blue.
- pixel_a_out  out  8  alpha.
- pat_cur  out  3  pattern currently displayed.

Behaviour:
Reset (rst low, async):
- All pixel outputs 0, pat_cur 0.
- Pending pattern invalid; dwell counter 0; scroll offset 0; latched hs/vs 0.

Frame start:
- sof = (hcnt==0 && vcnt==0), evaluated every cycle.
- At sof, latch hs=hsize and vs=vsize; these hold for the whole frame.
- Until the first sof after reset, hs=vs=0, so every pixel is inactive and outputs 0.

Pattern select:
- pat_load captures pat_sel into the pending register and sets pending valid.
- pat_sel >= NUM_PAT is captured as 0.
- A later pat_load before sof overwrites the pending value.
- At sof, if pending is valid: pat_cur <= pending, pending cleared, dwell <= 0.
- Otherwise, if auto_en && !pause: if dwell == DWELL_FRAMES-1, then dwell <= 0 and pat_cur <= (pat_cur+1) mod NUM_PAT (5 wraps to 0); else dwell <= dwell+1.
- pat_load on the same cycle as sof is captured but applies at the next sof. It has priority over auto-advance at that sof.
- Taking auto_en low freezes dwell at its current value; it is not cleared.

Scroll offset:
- At sof with !pause, offset <= offset+1.
- If offset+1 >= hs, offset wraps to 0.
- The offset is updated before the frame is drawn.

Pixel generation:
- Output is registered; latency is exactly 1 cycle from hcnt/vcnt to outputs.
- Inactive pixels (hcnt>=hs or vcnt>=vs) output RGBA 0.
- Colours are RGBA. "Opaque black" is 00_00_00_FF. "Clear" is all 0.
- Pattern 0, crosshair: opaque black where hcnt==hs>>1 or vcnt==vs>>1; else clear.
- Pattern 1, border: opaque black where hcnt==0, hcnt==hs-1, vcnt==0 or vcnt==vs-1; else clear.
- Pattern 2, box: opaque black where hs>>2 < hcnt < (hs>>2)+(hs>>1) and vs>>2 < vcnt < (vs>>2)+(vs>>1); else clear.
- Pattern 3, checker: FF_FF_FF_FF where hcnt[CHECK_LOG2]==vcnt[CHECK_LOG2]; else clear.
- Pattern 4, colour bars:
  - bar_w = max(1, hs>>3); bar index = min(7, hcnt / bar_w).
  - Compute the index with a per-line pixel counter and an index counter, both reset at hcnt==0. No divider.
  - Colours by index, alpha FF: white, yellow FFFF00, cyan 00FFFF, green, magenta, red, blue, black.
- Pattern 5, scroll: FF_00_00_FF where hcnt==offset; else clear.

Test Plan:
- Reset, then pat_load pat_sel=2 mid-frame, hsize=800/vsize=600 -> pat_cur stays 0 until the next sof. Box is opaque at (201,151) and (599,449); clear at (200,300) and (600,300). Output appears 1 cycle after the hcnt sample.
- auto_en=1, DWELL_FRAMES=2, from pat_cur=4 -> sequence 4,4,5,5,0,0 across sofs. Same run with pause=1 for 3 frames -> pat_cur holds for those frames.
- pat_load pat_sel=7 -> pat_cur becomes 0 at the next sof. pat_load asserted on the sof cycle with auto advance due -> the loaded value wins at the following sof and dwell resets.
- Pattern 4, hsize=800 -> bar_w=100: hcnt 99 white, 100 yellow, 799 black. hsize=4 -> bar_w=1: hcnt 0..3 give indices 0..3.
- Pattern 5, hsize=800: run 801 frames -> offset sequence 1,2,…,799,0,1. Red pixel only at hcnt==offset. Change hsize mid-frame -> geometry unchanged until the next sof.
- Assert rst low mid-frame with pattern 3 active -> outputs go to 0 immediately and pat_cur=0. Outputs stay 0 after rst high until the first sof.

Source files
------------

// File: rtl/test_pattern_gen.sv
// Overlay test-pattern generator: six selectable RGBA patterns, switched only at frame start.
// Latency: one pxlClk from hcnt/vcnt to the pixel outputs (registered).
// Backpressure: none; one pixel per cycle, follows the timing generator's counters.
module test_pattern_gen #(
   parameter int CNT_W        = 12,
   parameter int CHECK_LOG2   = 4,
   parameter int DWELL_FRAMES = 60,
   parameter int NUM_PAT      = 6
) (
   input  logic             pxlClk,
   input  logic             rst,
   input  logic [CNT_W-1:0] hcnt,
   input  logic [CNT_W-1:0] vcnt,
   input  logic [CNT_W-1:0] hsize,
   input  logic [CNT_W-1:0] vsize,
   input  logic             pause,
   input  logic             auto_en,
   input  logic [2:0]       pat_sel,
   input  logic             pat_load,
   output logic [7:0]       pixel_r_out,
   output logic [7:0]       pixel_g_out,
   output logic [7:0]       pixel_b_out,
   output logic [7:0]       pixel_a_out,
   output logic [2:0]       pat_cur
);

   localparam int DW_W = (DWELL_FRAMES < 2) ? 1 : $clog2(DWELL_FRAMES);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
   localparam logic [2:0]      PAT_LAST   = 3'(NUM_PAT - 1);

   logic [CNT_W-1:0] r_hs, r_vs, r_off, r_bar_cnt;
   logic [2:0]       r_pat, r_pend, r_bar_idx;
   logic             r_pend_vld;
   logic [DW_W-1:0]  r_dwell;
   logic [31:0]      r_px;

   logic             w_sof, w_active, w_in_box;
   logic [CNT_W-1:0] w_hs, w_vs, w_off, w_off_nxt, w_bar_w, w_bar_cnt_cur;
   logic [CNT_W:0]   w_off_inc, w_bx_lo, w_bx_hi, w_by_lo, w_by_hi;
   logic [2:0]       w_pat, w_pat_nxt, w_bar_idx_cur;
   logic [DW_W-1:0]  w_dwell_nxt;
   logic [23:0]      w_bar_rgb;
   logic [31:0]      w_rgba;

   // The sof cycle is drawn with the new frame's geometry, pattern and offset,
   // so pixel (0,0) already belongs to the new frame.
   assign w_sof = (hcnt == '0) && (vcnt == '0);
   assign w_hs  = w_sof ? hsize : r_hs;
   assign w_vs  = w_sof ? vsize : r_vs;

   // Pattern/dwell for the next frame: a pending host load beats auto-advance.
   always_comb begin
      w_pat_nxt   = r_pat;
      w_dwell_nxt = r_dwell;
      if (r_pend_vld) begin
         w_pat_nxt   = r_pend;
         w_dwell_nxt = '0;
      end else if (auto_en && !pause) begin
         if (r_dwell == DWELL_LAST) begin
            w_dwell_nxt = '0;
            w_pat_nxt   = (r_pat == PAT_LAST) ? 3'd0 : r_pat + 3'd1;
         end else begin
            w_dwell_nxt = r_dwell + DW_W'(1);
         end
      end
   end

   assign w_off_inc = {1'b0, r_off} + {{CNT_W{1'b0}}, 1'b1};
   assign w_off_nxt = pause ? r_off :
                      (w_off_inc >= {1'b0, w_hs}) ? '0 : w_off_inc[CNT_W-1:0];
   assign w_pat     = w_sof ? w_pat_nxt : r_pat;
   assign w_off     = w_sof ? w_off_nxt : r_off;

   // Frame-level state: geometry latch, pattern, dwell, scroll offset, pending load.
   always_ff @(posedge pxlClk or negedge rst) begin
      if (!rst) begin
         r_hs       <= '0;
         r_vs       <= '0;
         r_off      <= '0;
         r_pat      <= '0;
         r_dwell    <= '0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
      end else begin
         if (w_sof) begin
            r_hs    <= hsize;
            r_vs    <= vsize;
            r_off   <= w_off_nxt;
            r_pat   <= w_pat_nxt;
            r_dwell <= w_dwell_nxt;
         end
         // A load on the sof cycle itself is held for the following frame.
         if (pat_load) begin
            r_pend     <= (pat_sel >= 3'(NUM_PAT)) ? 3'd0 : pat_sel;
            r_pend_vld <= 1'b1;
         end else if (w_sof) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   // Colour-bar position without a divider: count pixels within the bar, bump index at bar end.
   assign w_bar_w       = ((w_hs >> 3) == '0) ? CNT_W'(1) : (w_hs >> 3);
   assign w_bar_cnt_cur = (hcnt == '0) ? '0   : r_bar_cnt;
   assign w_bar_idx_cur = (hcnt == '0) ? 3'd0 : r_bar_idx;

   // Advance the bar counters one pixel per cycle; index saturates at the last bar.
   always_ff @(posedge pxlClk or negedge rst) begin
      if (!rst) begin
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
      end else if (w_bar_cnt_cur == w_bar_w - CNT_W'(1)) begin
         r_bar_cnt <= '0;
         r_bar_idx <= (w_bar_idx_cur == 3'd7) ? 3'd7 : w_bar_idx_cur + 3'd1;
      end else begin
         r_bar_cnt <= w_bar_cnt_cur + CNT_W'(1);
         r_bar_idx <= w_bar_idx_cur;
      end
   end

   assign w_bx_lo  = {1'b0, (w_hs >> 2)};
   assign w_bx_hi  = {1'b0, (w_hs >> 2)} + {1'b0, (w_hs >> 1)};
   assign w_by_lo  = {1'b0, (w_vs >> 2)};
   assign w_by_hi  = {1'b0, (w_vs >> 2)} + {1'b0, (w_vs >> 1)};
   assign w_in_box = ({1'b0, hcnt} > w_bx_lo) && ({1'b0, hcnt} < w_bx_hi) &&
                     ({1'b0, vcnt} > w_by_lo) && ({1'b0, vcnt} < w_by_hi);
   assign w_active = (hcnt < w_hs) && (vcnt < w_vs);

   // Bar colour lookup by index.
   always_comb begin
      w_bar_rgb = 24'h000000;
      case (w_bar_idx_cur)
         3'd0:    w_bar_rgb = 24'hFFFFFF;
         3'd1:    w_bar_rgb = 24'hFFFF00;
         3'd2:    w_bar_rgb = 24'h00FFFF;
         3'd3:    w_bar_rgb = 24'h00FF00;
         3'd4:    w_bar_rgb = 24'hFF00FF;
         3'd5:    w_bar_rgb = 24'hFF0000;
         3'd6:    w_bar_rgb = 24'h0000FF;
         default: w_bar_rgb = 24'h000000;
      endcase
   end

   // Pixel colour for the current position and active pattern.
   always_comb begin
      w_rgba = 32'h0;
      if (w_active) begin
         case (w_pat)
            3'd0: if (hcnt == (w_hs >> 1) || vcnt == (w_vs >> 1)) w_rgba = 32'h000000FF;
            3'd1: if (hcnt == '0 || hcnt == w_hs - CNT_W'(1) ||
                      vcnt == '0 || vcnt == w_vs - CNT_W'(1))    w_rgba = 32'h000000FF;
            3'd2: if (w_in_box)                                  w_rgba = 32'h000000FF;
            3'd3: if (hcnt[CHECK_LOG2] == vcnt[CHECK_LOG2])      w_rgba = 32'hFFFFFFFF;
            3'd4: w_rgba = {w_bar_rgb, 8'hFF};
            3'd5: if (hcnt == w_off)                             w_rgba = 32'hFF0000FF;
            default: w_rgba = 32'h0;
         endcase
      end
   end

   // Output pixel register.
   always_ff @(posedge pxlClk or negedge rst) begin
      if (!rst) r_px <= '0;
      else      r_px <= w_rgba;
   end

   assign pixel_r_out = r_px[31:24];
   assign pixel_g_out = r_px[23:16];
   assign pixel_b_out = r_px[15:8];
   assign pixel_a_out = r_px[7:0];
   assign pat_cur     = r_pat;

endmodule
